shift_scheduler: RTL and testbench

SHIFT_SCHEDULER -- requirements
Module: shift_scheduler

---
 rtl/shift_scheduler_pkg.sv | 15 +
 rtl/shift_scheduler_if.sv | 18 +
 rtl/shift_tag_pipe.sv | 19 +
 rtl/shift_scheduler.sv | 61 ++++++
 tb/tb_shift_scheduler.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/shift_scheduler_pkg.sv
// shift_scheduler_pkg: shared shifter geometry, response tag type and sticky helper
package shift_scheduler_pkg;
  localparam int SH_STAGES = 4;
  localparam int DATA_W = 32;
  localparam int SHIFT_W = 5;
  typedef struct packed {
    logic valid;
    logic id;
    logic zero;
    logic sticky;
  } tag_t;
  function automatic logic sticky_of(input logic [DATA_W-1:0] d, input logic [SHIFT_W-1:0] s, input logic big);
    return big ? |d : |(d & ((DATA_W'(1) << s) - DATA_W'(1)));
  endfunction
endpackage

// File: rtl/shift_scheduler_if.sv
// shift_scheduler_if: two requesters (valid/ready/data/amt) and their shared response bus (rspN_valid, rsp_data, rsp_sticky)
interface shift_scheduler_if #(parameter int AMT_W = 8);
  import shift_scheduler_pkg::*;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic [AMT_W-1:0] req0_amt, req1_amt;
  logic rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp_data;
  logic rsp_sticky;
  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, req0_amt, req1_amt,
    input req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_sticky
  );
  modport slave (
    input req0_valid, req1_valid, req0_data, req1_data, req0_amt, req1_amt,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_sticky
  );
endinterface

// File: rtl/shift_tag_pipe.sv
// shift_tag_pipe: DEPTH-stage {valid,id,zero,sticky} delay line; clk, reset (async high), din in, dout out
module shift_tag_pipe import shift_scheduler_pkg::*; #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic reset,
  input  tag_t din,
  output tag_t dout
);
  tag_t st [DEPTH];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= '0;
    end else begin
      st[0] <= din;
      for (int i = 1; i < DEPTH; i++) st[i] <= st[i-1];
    end
  assign dout = st[DEPTH-1];
endmodule

// File: rtl/shift_scheduler.sv
// shift_scheduler: round-robin two-requester front end for an external pipelined right shifter; clk, reset (async high), bus (slave), sh_x/sh_s to shifter, sh_cout from shifter, inflight count
module shift_scheduler #(
  parameter int SH_STAGES = shift_scheduler_pkg::SH_STAGES,
  parameter int AMT_W = 8
) (
  input  logic clk,
  input  logic reset,
  shift_scheduler_if.slave bus,
  output logic [shift_scheduler_pkg::DATA_W-1:0] sh_x,
  output logic [shift_scheduler_pkg::SHIFT_W-1:0] sh_s,
  input  logic [shift_scheduler_pkg::DATA_W-1:0] sh_cout,
  output logic [2:0] inflight
);
  import shift_scheduler_pkg::*;
  logic ptr, g0, g1, acc, big;
  logic [DATA_W-1:0] d;
  logic [AMT_W-1:0] a;
  tag_t tag_in, tag_out;
  always_comb begin
    g1 = !reset && bus.req1_valid && (!bus.req0_valid || ptr);
    g0 = !reset && bus.req0_valid && !g1;
    acc = g0 || g1;
    d = g1 ? bus.req1_data : bus.req0_data;
    a = g1 ? bus.req1_amt : bus.req0_amt;
    big = 32'(a) >= 32;
    tag_in = '{valid: acc, id: g1, zero: big, sticky: sticky_of(d, a[SHIFT_W-1:0], big)};
  end
  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;
  // tag is captured on the same edge as sh_x, so SH_STAGES+1 stages line it up with sh_cout
  shift_tag_pipe #(.DEPTH(SH_STAGES + 1)) u_tags (
    .clk(clk),
    .reset(reset),
    .din(tag_in),
    .dout(tag_out)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr <= 1'b0;
      sh_x <= '0;
      sh_s <= '0;
      inflight <= '0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp_data <= '0;
      bus.rsp_sticky <= 1'b0;
    end else begin
      if (acc) begin
        ptr <= g0;
        sh_x <= big ? '0 : d;
        sh_s <= a[SHIFT_W-1:0];
      end
      bus.rsp0_valid <= tag_out.valid && !tag_out.id;
      bus.rsp1_valid <= tag_out.valid && tag_out.id;
      if (tag_out.valid) begin
        bus.rsp_data <= tag_out.zero ? '0 : sh_cout;
        bus.rsp_sticky <= tag_out.sticky;
      end
      inflight <= inflight + 3'(acc) - 3'(bus.rsp0_valid || bus.rsp1_valid);
    end
endmodule

// File: tb/tb_shift_scheduler.sv
// tb_shift_scheduler: random and directed stimulus checked each cycle against a queue-based reference model
module tb_shift_scheduler;
  logic clk = 0, reset = 1;
  logic [31:0] sh_x, sh_cout;
  logic [4:0] sh_s;
  logic [2:0] inflight;
  int checks = 0, errors = 0, cyc = 0;
  shift_scheduler_if #(.AMT_W(8)) bus ();
  shift_scheduler #(.SH_STAGES(4), .AMT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .sh_x(sh_x), .sh_s(sh_s), .sh_cout(sh_cout), .inflight(inflight)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic [31:0] sp [4];
  always @(posedge clk) begin
    sp[0] <= sh_x >> sh_s;
    for (int i = 1; i < 4; i++) sp[i] <= sp[i-1];
  end
  assign sh_cout = sp[3];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h cyc=%0d", n, act, exp, cyc);
    end
  endtask

  typedef struct {
    int due;
    bit id;
    logic [31:0] d;
    bit s;
  } exp_t;
  exp_t q[$];
  exp_t e;
  bit m_ptr, m_big, eg0, eg1, s;
  logic [31:0] m_shx, last_d, dd;
  logic [4:0] m_shs;
  bit last_s;
  int a;
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_ptr = 0; m_shx = 0; m_shs = 0; m_big = 0; last_d = 0; last_s = 0;
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_rsp0", bus.rsp0_valid, 0);
      chk("rst_rsp1", bus.rsp1_valid, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_data", bus.rsp_data, 0);
      chk("rst_shx", sh_x, 0);
    end else begin
      chk("inflight", inflight, q.size());
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rsp0_valid", bus.rsp0_valid, !e.id);
        chk("rsp1_valid", bus.rsp1_valid, e.id);
        chk("rsp_data", bus.rsp_data, e.d);
        chk("rsp_sticky", bus.rsp_sticky, e.s);
        last_d = e.d; last_s = e.s;
      end else begin
        chk("idle_rsp0", bus.rsp0_valid, 0);
        chk("idle_rsp1", bus.rsp1_valid, 0);
        chk("hold_data", bus.rsp_data, last_d);
        chk("hold_sticky", bus.rsp_sticky, last_s);
      end
      chk("sh_x", sh_x, m_shx);
      if (!m_big) chk("sh_s", sh_s, m_shs);
      eg1 = bus.req1_valid && (!bus.req0_valid || m_ptr);
      eg0 = bus.req0_valid && !eg1;
      chk("ready0", bus.req0_ready, eg0);
      chk("ready1", bus.req1_ready, eg1);
      if (eg0 || eg1) begin
        dd = eg1 ? bus.req1_data : bus.req0_data;
        a = eg1 ? int'(bus.req1_amt) : int'(bus.req0_amt);
        s = 0;
        for (int i = 0; i < 32; i++) if (i < a && dd[i]) s = 1;
        q.push_back('{due: cyc + 6, id: eg1, d: (a >= 32) ? 32'd0 : dd >> a, s: s});
        m_big = a >= 32;
        m_shx = m_big ? 32'd0 : dd;
        m_shs = 5'(a);
        m_ptr = eg0;
      end
    end
  end

  task automatic drive(input bit v0, input bit v1, input logic [31:0] d0, input logic [31:0] d1, input logic [7:0] a0, input logic [7:0] a1);
    bus.req0_valid = v0; bus.req1_valid = v1;
    bus.req0_data = d0; bus.req1_data = d1;
    bus.req0_amt = a0; bus.req1_amt = a1;
  endtask

  task automatic pin(input bit id, input logic [31:0] d, input logic [7:0] amt, input logic [31:0] ed, input bit es);
    int t0;
    bit seen;
    @(posedge clk); #1;
    drive(!id, id, d, d, amt, amt);
    t0 = cyc;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (id ? bus.rsp1_valid : bus.rsp0_valid) begin
        seen = 1;
        chk("pin_latency", cyc - t0, 6);
        chk("pin_data", bus.rsp_data, ed);
        chk("pin_sticky", bus.rsp_sticky, es);
      end
    end
    if (!seen) chk("pin_timeout", 0, 1);
  endtask

  int n, peak;
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    pin(0, 32'h80000000, 4, 32'h08000000, 0);
    pin(1, 32'h0001FFFF, 16, 32'h00000001, 1);
    pin(1, 32'h0001FFFF, 17, 32'h00000000, 1);
    pin(0, 32'h00000001, 40, 32'h00000000, 1);
    pin(0, 32'h12345678, 0, 32'h12345678, 0);
    pin(1, 32'hFFFFFFFF, 31, 32'h00000001, 1);
    pin(0, 32'h00000001, 32, 32'h00000000, 1);
    @(posedge clk); #1;
    drive(1, 0, 32'hDEADBEEF, 0, 3, 0);
    @(negedge clk);
    chk("pre_reset_accept", bus.req0_ready, 1);
    @(posedge clk); #1; drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1; reset = 0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(bus.rsp0_valid) + int'(bus.rsp1_valid);
    end
    chk("no_rsp_after_reset", n, 0);
    n = 0; peak = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(1, 1, $urandom, $urandom, 8'($urandom_range(0, 40)), 8'($urandom_range(0, 40)));
      @(negedge clk);
      chk("burst_ready0", bus.req0_ready, (i % 2) == 0);
      chk("burst_ready1", bus.req1_ready, (i % 2) == 1);
      n += int'(bus.rsp0_valid) + int'(bus.rsp1_valid);
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    @(posedge clk); #1; drive(0, 0, 0, 0, 0, 0);
    repeat (10) begin
      @(negedge clk);
      n += int'(bus.rsp0_valid) + int'(bus.rsp1_valid);
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    chk("burst_rsp_count", n, 8);
    chk("burst_peak", peak, 6);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom, $urandom,
            8'($urandom_range(0, 40)), 8'($urandom_range(0, 40)));
    end
    @(posedge clk); #1; reset = 0; drive(0, 0, 0, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
